// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings,
// default geometry and the small helpers used by the loader datapath.
package inst_mem_loader_pkg;

    localparam int          WORD_W          = 32;
    localparam int          DEPTH_WORDS_DEF = 256;
    localparam logic [31:0] BASE_ADDR_DEF   = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // States in which the loader consumes stream bytes.
    function automatic logic state_accepts(input state_e s);
        logic r;
        case (s)
            ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inst_mem_loader_byte_packer.sv
// Assembles four stream bytes, most significant first, into one 32-bit word.
// word_valid_o is raised combinationally while the fourth byte is presented.
module byte_packer
    import inst_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic [7:0]        byte_i,
    input  logic              valid_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [WORD_W-1:0] shift_q;
    logic [1:0]        cnt_q;

    assign word_o       = {shift_q[WORD_W-9:0], byte_i};
    assign word_valid_o = valid_i && (cnt_q == 2'd3);

    // Shift register and byte position; clear drops any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
        end else if (clear_i) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
        end else if (valid_i) begin
            shift_q <= word_o;
            cnt_q   <= cnt_q + 2'd1;
        end else begin
            shift_q <= shift_q;
            cnt_q   <= cnt_q;
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads the instruction RAM from a framed byte stream (length, words, XOR
// checksum) and keeps the CPU held in reset until a load verifies.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [8:0]  words_loaded
);

    localparam logic [15:0] DEPTH_L   = 16'(DEPTH_WORDS);
    localparam logic [8:0]  WORDS_MAX = 9'(DEPTH_WORDS);

    state_e       state_q, state_d;
    logic [7:0]   len_hi_q;
    logic [15:0]  len_q;
    logic [7:0]   csum_q;
    logic [8:0]   words_q;
    logic         in_ready_q;
    logic         wr_en_q;
    logic [31:0]  wr_addr_q;
    logic [31:0]  wr_data_q;
    logic         cpu_hold_q;
    logic         done_q;
    logic         error_q;

    logic         accept_s;
    logic         start_ok_s;
    logic         data_acc_s;
    logic [15:0]  len_s;
    logic         last_word_s;
    logic [31:0]  word_s;
    logic         word_valid_s;

    assign accept_s    = in_valid && in_ready_q;
    assign start_ok_s  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign data_acc_s  = accept_s && (state_q == ST_DATA);
    assign len_s       = {len_hi_q, in_byte};
    // words_q already counts every earlier word, so it is the index of the word completing now.
    assign last_word_s = ((16'(words_q) + 16'd1) == len_q);

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (start_ok_s),
        .byte_i       (in_byte),
        .valid_i      (data_acc_s),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // Next-state decode for the frame parser.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LEN_HI;
                else       state_d = ST_IDLE;
            end
            ST_LEN_HI: begin
                if (accept_s) state_d = ST_LEN_LO;
                else          state_d = ST_LEN_HI;
            end
            ST_LEN_LO: begin
                if (!accept_s)             state_d = ST_LEN_LO;
                else if (len_s == 16'd0)   state_d = ST_CSUM;
                else if (len_s > DEPTH_L)  state_d = ST_ERR;
                else                       state_d = ST_DATA;
            end
            ST_DATA: begin
                if (word_valid_s && last_word_s) state_d = ST_CSUM;
                else                             state_d = ST_DATA;
            end
            ST_CSUM: begin
                if (!accept_s)               state_d = ST_CSUM;
                else if (csum_q == in_byte)  state_d = ST_DONE;
                else                         state_d = ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (start) state_d = ST_LEN_HI;
                else       state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and the status outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= state_accepts(state_d);
            cpu_hold_q <= (state_d != ST_DONE);
            done_q     <= (state_d == ST_DONE);
            error_q    <= (state_d == ST_ERR);
        end
    end

    // Frame length capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_hi_q <= 8'd0;
            len_q    <= 16'd0;
        end else if (accept_s && (state_q == ST_LEN_HI)) begin
            len_hi_q <= in_byte;
            len_q    <= len_q;
        end else if (accept_s && (state_q == ST_LEN_LO)) begin
            len_hi_q <= len_hi_q;
            len_q    <= len_s;
        end else begin
            len_hi_q <= len_hi_q;
            len_q    <= len_q;
        end
    end

    // Checksum accumulator and word counter; a fresh start wipes both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q  <= 8'd0;
            words_q <= 9'd0;
        end else if (start_ok_s) begin
            csum_q  <= 8'd0;
            words_q <= 9'd0;
        end else begin
            if (data_acc_s) csum_q <= csum_next(csum_q, in_byte);
            else            csum_q <= csum_q;
            if (word_valid_s && (words_q != WORDS_MAX)) words_q <= words_q + 9'd1;
            else                                        words_q <= words_q;
        end
    end

    // RAM write port: strobe one cycle after the fourth byte of each word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_data_q <= 32'd0;
        end else if (word_valid_s) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= BASE_ADDR + {21'd0, words_q, 2'b00};
            wr_data_q <= word_s;
        end else begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= wr_addr_q;
            wr_data_q <= wr_data_q;
        end
    end

    assign in_ready     = in_ready_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule
